// File: rtl/mmio_bus.sv
// Memory-mapped I/O bridge: one CPU strobe fans out to one of NSLOT 256-byte
// peripheral slots, waits for ack (or zero-wait), and aborts on timeout or unmapped slot.
module mmio_bus #(
    parameter int               NSLOT    = 4,
    parameter logic [NSLOT-1:0] ZW_MASK  = '1,
    parameter int               TIMEOUT  = 16,
    parameter logic [7:0]       ERR_DATA = 8'hFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 re,
    input  logic                 we,
    input  logic [14:0]          addr,
    input  logic [7:0]           data_write,
    output logic [7:0]           data_read,
    output logic                 stall,
    output logic [NSLOT-1:0]     psel,
    output logic [NSLOT-1:0]     pre,
    output logic [NSLOT-1:0]     pwe,
    output logic [7:0]           paddr,
    output logic [7:0]           pwdata,
    input  logic [8*NSLOT-1:0]   prdata,
    input  logic [NSLOT-1:0]     pack,
    output logic                 err,
    output logic [14:0]          err_addr,
    input  logic                 err_clr
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t             state_reg, state_next;
    logic [14:0]        addr_reg, addr_next;
    logic               wr_reg, wr_next;
    logic [7:0]         pwdata_reg, pwdata_next;
    logic [NSLOT-1:0]   psel_reg, psel_next;
    logic [NSLOT-1:0]   pre_reg, pre_next;
    logic [NSLOT-1:0]   pwe_reg, pwe_next;
    logic [7:0]         cnt_reg, cnt_next;
    logic [7:0]         data_read_reg, data_read_next;
    logic               err_reg, err_next;
    logic [14:0]        err_addr_reg, err_addr_next;

    logic [NSLOT-1:0]   acc_sel;
    logic [7:0]         rdata_mux;
    logic               done;
    logic               abort;

    // One-hot decode of the incoming address; unmapped slots decode to all zeros.
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
        assign acc_sel[gi] = (addr[14:8] == 7'(gi));
    end

    always_comb begin
        rdata_mux = 8'h00;
        for (int i = 0; i < NSLOT; i++) begin
            if (psel_reg[i]) rdata_mux = rdata_mux | prdata[8*i +: 8];
        end
    end

    // psel_reg is one-hot on a mapped slot and zero when the slot is unmapped.
    assign done  = |(psel_reg & (pack | ZW_MASK));
    assign abort = !done && (!(|psel_reg) || (cnt_reg == 8'(TIMEOUT - 1)));

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        wr_next        = wr_reg;
        pwdata_next    = pwdata_reg;
        psel_next      = psel_reg;
        pre_next       = pre_reg;
        pwe_next       = pwe_reg;
        cnt_next       = cnt_reg;
        data_read_next = data_read_reg;
        err_next       = err_reg;
        err_addr_next  = err_addr_reg;

        if (err_clr) err_next = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (re || we) begin
                    state_next  = S_WAIT;
                    addr_next   = addr;
                    wr_next     = we;
                    pwdata_next = data_write;
                    psel_next   = acc_sel;
                    pre_next    = we ? '0 : acc_sel;
                    pwe_next    = we ? acc_sel : '0;
                    cnt_next    = 8'h00;
                end
            end
            S_WAIT: begin
                if (done || abort) begin
                    state_next = S_IDLE;
                    psel_next  = '0;
                    pre_next   = '0;
                    pwe_next   = '0;
                    if (!wr_reg) data_read_next = done ? rdata_mux : ERR_DATA;
                    if (abort) begin
                        // A fresh error beats a simultaneous clear and re-captures the address.
                        if (!err_reg || err_clr) err_addr_next = addr_reg;
                        err_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 8'h01;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            addr_reg      <= '0;
            wr_reg        <= 1'b0;
            pwdata_reg    <= '0;
            psel_reg      <= '0;
            pre_reg       <= '0;
            pwe_reg       <= '0;
            cnt_reg       <= '0;
            data_read_reg <= 8'h00;
            err_reg       <= 1'b0;
            err_addr_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            wr_reg        <= wr_next;
            pwdata_reg    <= pwdata_next;
            psel_reg      <= psel_next;
            pre_reg       <= pre_next;
            pwe_reg       <= pwe_next;
            cnt_reg       <= cnt_next;
            data_read_reg <= data_read_next;
            err_reg       <= err_next;
            err_addr_reg  <= err_addr_next;
        end
    end

    assign stall     = (state_reg == S_WAIT);
    assign psel      = psel_reg;
    assign pre       = pre_reg;
    assign pwe       = pwe_reg;
    assign paddr     = addr_reg[7:0];
    assign pwdata    = pwdata_reg;
    assign data_read = data_read_reg;
    assign err       = err_reg;
    assign err_addr  = err_addr_reg;

endmodule

// File: tb/tb_mmio_bus.sv
// Bench for mmio_bus: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model.
module tb_mmio_bus;
    localparam int         NSLOT   = 4;
    localparam logic [3:0] ZW      = 4'b0111;
    localparam int         TIMEOUT = 16;
    localparam logic [7:0] ERRD    = 8'hFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        re, we, err_clr;
    logic [14:0] addr;
    logic [7:0]  data_write, data_read, paddr, pwdata;
    logic        stall, err;
    logic [3:0]  psel, pre, pwe, pack;
    logic [31:0] prdata;
    logic [14:0] err_addr;

    mmio_bus #(.NSLOT(NSLOT), .ZW_MASK(ZW), .TIMEOUT(TIMEOUT), .ERR_DATA(ERRD)) dut (
        .clk(clk), .rst_n(rst_n), .re(re), .we(we), .addr(addr),
        .data_write(data_write), .data_read(data_read), .stall(stall),
        .psel(psel), .pre(pre), .pwe(pwe), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pack(pack), .err(err), .err_addr(err_addr),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    // Transaction-level model: an in-flight transfer and how many wait cycles it has used.
    bit          m_busy;
    bit          m_write;
    logic [14:0] m_addr;
    logic [7:0]  m_pwdata;
    int          m_elapsed;
    logic [7:0]  m_data_read;
    bit          m_err;
    logic [14:0] m_err_addr;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_busy = 0; m_write = 0; m_addr = '0; m_pwdata = '0; m_elapsed = 0;
        m_data_read = 8'h00; m_err = 0; m_err_addr = '0;
    endtask

    task automatic model_edge();
        int  s;
        bit  fin, ab;
        bit  new_err;
        logic [14:0] new_ea;
        if (!rst_n) return;
        new_err = err_clr ? 1'b0 : m_err;
        new_ea  = m_err_addr;
        if (m_busy) begin
            s = int'(m_addr[14:8]);
            fin = 0; ab = 0;
            if (s >= NSLOT)                   ab = 1;
            else if (ZW[s] || pack[s])        fin = 1;
            else if (m_elapsed == TIMEOUT-1)  ab = 1;
            else                              m_elapsed++;
            if (fin || ab) begin
                m_busy = 0;
                if (!m_write) m_data_read = fin ? prdata[8*s +: 8] : ERRD;
            end
            if (ab) begin
                if (!m_err || err_clr) new_ea = m_addr;
                new_err = 1;
            end
        end else if (re || we) begin
            m_busy = 1; m_write = we; m_addr = addr; m_pwdata = data_write; m_elapsed = 0;
        end
        m_err = new_err;
        m_err_addr = new_ea;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            logic [3:0] e_sel;
            e_sel = (m_busy && m_addr[14:8] < NSLOT) ? 4'(1 << m_addr[14:8]) : 4'b0;
            chk("stall", 32'(stall), 32'(m_busy));
            chk("psel", 32'(psel), 32'(e_sel));
            chk("pre", 32'(pre), 32'(m_write ? 4'b0 : e_sel));
            chk("pwe", 32'(pwe), 32'(m_write ? e_sel : 4'b0));
            chk("paddr", 32'(paddr), 32'(m_addr[7:0]));
            chk("pwdata", 32'(pwdata), 32'(m_pwdata));
            chk("data_read", 32'(data_read), 32'(m_data_read));
            chk("err", 32'(err), 32'(m_err));
            chk("err_addr", 32'(err_addr), 32'(m_err_addr));
        end
    end

    task automatic drain();
        re = 0; we = 0; pack = 4'b1111; err_clr = 0;
        for (int i = 0; i < 40 && m_busy; i++) tick();
        chk("drain_idle", 32'(stall), 32'(0));
        pack = 4'b0;
    endtask

    initial begin
        int n;
        rst_n = 1; re = 0; we = 0; err_clr = 0; addr = '0; data_write = '0;
        pack = '0; prdata = '0;
        #2 rst_n = 0;
        m_reset();
        checking = 1'b1;
        tick(); tick();
        chk("rst_stall", 32'(stall), 32'(0));
        chk("rst_psel", 32'(psel), 32'(0));
        chk("rst_data_read", 32'(data_read), 32'(0));
        chk("rst_err_addr", 32'(err_addr), 32'(0));
        rst_n = 1;
        tick();

        // Zero-wait read on slot 0
        prdata = 32'h0000_00A5; addr = 15'h0012; re = 1;
        tick(); re = 0;
        chk("rd0_psel_t1", 32'(psel), 32'h1);
        chk("rd0_pre_t1", 32'(pre), 32'h1);
        tick();
        chk("rd0_psel_t2", 32'(psel), 32'h0);
        chk("rd0_data", 32'(data_read), 32'hA5);
        chk("rd0_stall_t2", 32'(stall), 32'h0);

        // Acked write on slot 3, ack arrives on the fourth wait cycle
        addr = 15'h0305; data_write = 8'h3C; we = 1;
        tick(); we = 0;
        chk("wr3_paddr", 32'(paddr), 32'h05);
        chk("wr3_pwdata", 32'(pwdata), 32'h3C);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (pwe[3]) n++;
            pack = (i == 3) ? 4'b1000 : 4'b0000;
            tick();
        end
        pack = 4'b0;
        chk("wr3_pwe_cycles", 32'(n), 32'd4);
        chk("wr3_data_read_kept", 32'(data_read), 32'hA5);

        // Timeout read on slot 3
        addr = 15'h0301; re = 1;
        tick(); re = 0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!stall) break;
            n++;
            tick();
        end
        chk("to_stall_cycles", 32'(n), 32'd16);
        chk("to_data", 32'(data_read), 32'hFF);
        chk("to_err", 32'(err), 32'h1);
        chk("to_err_addr", 32'(err_addr), 32'h0301);

        // Unmapped read while err already set
        addr = 15'h0700; re = 1;
        tick(); re = 0;
        chk("um_psel", 32'(psel), 32'h0);
        chk("um_stall_t1", 32'(stall), 32'h1);
        tick();
        chk("um_stall_t2", 32'(stall), 32'h0);
        chk("um_data", 32'(data_read), 32'hFF);
        chk("um_err_addr", 32'(err_addr), 32'h0301);
        err_clr = 1; tick(); err_clr = 0;
        chk("clr_err", 32'(err), 32'h0);

        // re+we together is a write; strobe during stall ignored
        addr = 15'h0100; data_write = 8'h5A; re = 1; we = 1;
        tick();
        chk("rw_pwe", 32'(pwe), 32'h2);
        chk("rw_pre", 32'(pre), 32'h0);
        addr = 15'h0200; re = 1; we = 0;
        tick(); re = 0;
        chk("rw_ignored_stall", 32'(stall), 32'h0);
        chk("rw_err", 32'(err), 32'h0);

        // Reset in the middle of a wait
        addr = 15'h0302; re = 1;
        tick(); re = 0;
        tick();
        rst_n = 0; m_reset(); #1;
        chk("mrst_psel", 32'(psel), 32'h0);
        chk("mrst_stall", 32'(stall), 32'h0);
        chk("mrst_err", 32'(err), 32'h0);
        tick();
        rst_n = 1;
        addr = 15'h0001; re = 1;
        tick(); re = 0;
        chk("post_rst_accept", 32'(psel), 32'h1);
        tick();

        // Random traffic, with quiet phases where slot 3 never acks
        for (int c = 0; c < 3000; c++) begin
            bit quiet;
            quiet = ((c / 250) % 2) == 1;
            re = ($urandom_range(0, 3) == 0);
            we = ($urandom_range(0, 3) == 0);
            addr = {4'b0, 3'($urandom_range(0, 5)), 8'($urandom)};
            data_write = 8'($urandom);
            prdata = $urandom;
            pack = 4'($urandom) & (quiet ? 4'b0111 : 4'b1111);
            err_clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
